// File: rtl/decoder3to8_seq.sv
// Registered 3-to-8 decoder with a valid/ready output stage and a
// self-test sweep that walks codes 0..7 through the same output register.
module decoder3to8_seq #(
  parameter int ACTIVE_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  input  logic       sweep_start,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_onehot,
  output logic [2:0] out_code,
  output logic       sweep_done
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

  localparam logic [7:0] IDLE_WORD = (ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;

  // Polarity is folded in here so the output register holds the final pin value.
  function automatic logic [7:0] decode(input logic [2:0] code);
    logic [7:0] hot;
    hot = 8'h01 << code;
    decode = (ACTIVE_HIGH != 0) ? hot : ~hot;
  endfunction

  state_t     state_r, state_s;
  logic       valid_r, valid_s;
  logic [7:0] onehot_r, onehot_s;
  logic [2:0] code_r, code_s;
  logic [2:0] sweep_cnt_r, sweep_cnt_s;
  logic       done_r, done_s;
  logic       free_s, ready_s, handshake_s, sweep_go_s;

  // Handshake qualifiers; in_ready is forced low while reset is held.
  always_comb begin
    free_s      = ~valid_r | out_ready;
    ready_s     = rst_n & (state_r == ST_IDLE) & free_s & ~sweep_start;
    handshake_s = in_valid & ready_s;
    sweep_go_s  = (state_r == ST_IDLE) & sweep_start & free_s;
  end

  // Next-state and output-register load decisions.
  always_comb begin
    state_s     = state_r;
    valid_s     = valid_r & ~out_ready;
    code_s      = code_r;
    sweep_cnt_s = sweep_cnt_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sweep_go_s) begin
          state_s     = ST_SWEEP;
          valid_s     = 1'b1;
          code_s      = 3'd0;
          sweep_cnt_s = 3'd0;
        end else if (handshake_s) begin
          valid_s = 1'b1;
          code_s  = in_code;
        end else begin
          valid_s = valid_r & ~out_ready;
        end
      end
      ST_SWEEP: begin
        if (valid_r && out_ready) begin
          if (sweep_cnt_r == 3'd7) begin
            state_s     = ST_IDLE;
            valid_s     = 1'b0;
            sweep_cnt_s = 3'd0;
            done_s      = 1'b1;
          end else begin
            sweep_cnt_s = sweep_cnt_r + 3'd1;
            valid_s     = 1'b1;
            code_s      = sweep_cnt_r + 3'd1;
          end
        end else begin
          valid_s = valid_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
    // An empty register always shows the idle word and code 0.
    if (valid_s) begin
      onehot_s = decode(code_s);
    end else begin
      code_s   = 3'd0;
      onehot_s = IDLE_WORD;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      valid_r     <= 1'b0;
      onehot_r    <= IDLE_WORD;
      code_r      <= 3'd0;
      sweep_cnt_r <= 3'd0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      valid_r     <= valid_s;
      onehot_r    <= onehot_s;
      code_r      <= code_s;
      sweep_cnt_r <= sweep_cnt_s;
      done_r      <= done_s;
    end
  end

  assign in_ready   = ready_s;
  assign out_valid  = valid_r;
  assign out_onehot = onehot_r;
  assign out_code   = code_r;
  assign sweep_done = done_r;

endmodule
